// File: rtl/score_board_controller.sv
// score_board_controller: live score, sorted top-N leaderboard with a
// multi-cycle insertion FSM, and a view scheduler feeding a sequential
// double-dabble BCD converter for the 7-seg display.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   increment          one-cycle pulse, live score +1 (saturating)
//   isDead             one-cycle pulse, commit live score to leaderboard
//   auto_mode          1 = rotate views on dwell timer, 0 = manual
//   sel_idx            manual view: 0 = live score, k = rank k
//   busy               insertion in progress
//   curr_score         live score
//   hex0..hex3_out     BCD ones/tens/hundreds/thousands of shown value
//   hex5_out           index of the view currently shown
module score_board_controller #(
  parameter int SCORE_W      = 11,
  parameter int ENTRIES      = 3,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               increment,
  input  logic               isDead,
  input  logic               auto_mode,
  input  logic [1:0]         sel_idx,
  output logic               busy,
  output logic [SCORE_W-1:0] curr_score,
  output logic [3:0]         hex0_out,
  output logic [3:0]         hex1_out,
  output logic [3:0]         hex2_out,
  output logic [3:0]         hex3_out,
  output logic [3:0]         hex5_out
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int VW = $clog2(ENTRIES + 1);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int CW = $clog2(SCORE_W);

  localparam logic [SCORE_W-1:0] SC_MAX   = '1;
  localparam logic [IW-1:0]      IDX_LAST = IW'(ENTRIES - 1);
  localparam logic [VW-1:0]      V_LAST   = VW'(ENTRIES);
  localparam logic [DW-1:0]      DW_LAST  = DW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]      SH_LAST  = CW'(SCORE_W - 1);

  // ---------------------------------------------------------------
  // Insertion FSM
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_INS
  } ins_st_t;

  ins_st_t r_ins_st;
  ins_st_t w_ins_nx;

  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_cand;
  logic [SCORE_W-1:0] r_tab [ENTRIES];
  logic [IW-1:0]      r_idx;

  logic w_gt;
  logic w_start;
  logic w_step;
  logic w_ins;
  logic w_busy;

  // Strictly greater: ties never displace an existing entry.
  assign w_gt = r_cand > r_tab[r_idx];

  always_ff @(posedge clk) begin
    if (rst) r_ins_st <= S_IDLE;
    else     r_ins_st <= w_ins_nx;
  end

  always_comb begin
    w_ins_nx = r_ins_st;
    unique case (r_ins_st)
      S_IDLE: begin
        if (isDead) w_ins_nx = S_CMP;
      end
      S_CMP: begin
        if (w_gt)
          w_ins_nx = S_INS;
        else if (r_idx == IDX_LAST)
          w_ins_nx = S_IDLE;
      end
      S_INS:   w_ins_nx = S_IDLE;
      default: w_ins_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_start = 1'b0;
    w_step  = 1'b0;
    w_ins   = 1'b0;
    unique case (r_ins_st)
      S_IDLE: w_start = isDead;
      S_CMP: begin
        w_busy = 1'b1;
        w_step = !w_gt && (r_idx != IDX_LAST);
      end
      S_INS: begin
        w_busy = 1'b1;
        w_ins  = 1'b1;
      end
      default: ;
    endcase
  end

  // Score counter and leaderboard storage.
  // isDead (when idle) takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= '0;
      r_cand  <= '0;
      r_idx   <= '0;
      for (int j = 0; j < ENTRIES; j++)
        r_tab[j] <= '0;
    end else begin
      if (w_start) begin
        r_cand  <= r_score;
        r_score <= '0;
        r_idx   <= '0;
      end else if (increment && r_score != SC_MAX) begin
        r_score <= r_score + 1'b1;
      end
      if (w_step)
        r_idx <= r_idx + 1'b1;
      if (w_ins) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (IW'(j) == r_idx)
            r_tab[j] <= r_cand;
          else if (IW'(j) > r_idx)
            r_tab[j] <= r_tab[(j > 0) ? j - 1 : 0];
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // View scheduler
  // ---------------------------------------------------------------
  logic [VW-1:0] r_view;
  logic [DW-1:0] r_dwell;
  logic          w_sel_ok;

  assign w_sel_ok = int'(sel_idx) <= ENTRIES;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_view  <= '0;
      r_dwell <= '0;
    end else if (auto_mode) begin
      if (r_dwell == DW_LAST) begin
        r_dwell <= '0;
        r_view  <= (r_view == V_LAST) ? '0 : r_view + 1'b1;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end else begin
      // Holding the counter at 0 gives a full dwell on re-entry.
      r_dwell <= '0;
      r_view  <= w_sel_ok ? VW'(sel_idx) : '0;
    end
  end

  logic [SCORE_W-1:0] w_sel;

  always_comb begin
    w_sel = r_score;
    for (int k = 1; k <= ENTRIES; k++) begin
      if (r_view == VW'(k))
        w_sel = r_tab[k-1];
    end
  end

  // ---------------------------------------------------------------
  // Double-dabble BCD engine (free-running LOAD/SHIFT/UPDATE)
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {
    B_LOAD,
    B_SHIFT,
    B_UPD
  } bcd_st_t;

  bcd_st_t r_b_st;
  bcd_st_t w_b_nx;

  logic [SCORE_W-1:0] r_bin;
  logic [15:0]        r_bcd;
  logic [CW-1:0]      r_cnt;
  logic [VW-1:0]      r_vlat;
  logic [3:0]         r_hex0;
  logic [3:0]         r_hex1;
  logic [3:0]         r_hex2;
  logic [3:0]         r_hex3;
  logic [3:0]         r_hex5;

  logic        w_ld;
  logic        w_sh;
  logic        w_up;
  logic [14:0] w_adj;

  always_ff @(posedge clk) begin
    if (rst) r_b_st <= B_LOAD;
    else     r_b_st <= w_b_nx;
  end

  always_comb begin
    w_b_nx = r_b_st;
    unique case (r_b_st)
      B_LOAD:  w_b_nx = B_SHIFT;
      B_SHIFT: begin
        if (r_cnt == SH_LAST) w_b_nx = B_UPD;
      end
      B_UPD:   w_b_nx = B_LOAD;
      default: w_b_nx = B_LOAD;
    endcase
  end

  always_comb begin
    w_ld = 1'b0;
    w_sh = 1'b0;
    w_up = 1'b0;
    unique case (r_b_st)
      B_LOAD:  w_ld = 1'b1;
      B_SHIFT: w_sh = 1'b1;
      B_UPD:   w_up = 1'b1;
      default: ;
    endcase
  end

  // The thousands nibble only reaches 5 for results above 9999, which
  // cannot be shown on four digits, so it is passed through unadjusted.
  always_comb begin
    w_adj = r_bcd[14:0];
    for (int n = 0; n < 3; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5)
        w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_vlat <= '0;
      r_hex0 <= '0;
      r_hex1 <= '0;
      r_hex2 <= '0;
      r_hex3 <= '0;
      r_hex5 <= '0;
    end else begin
      if (w_ld) begin
        r_bin  <= w_sel;
        r_vlat <= r_view;
        r_bcd  <= '0;
        r_cnt  <= '0;
      end
      if (w_sh) begin
        r_bcd <= {w_adj, r_bin[SCORE_W-1]};
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_up) begin
        r_hex0 <= r_bcd[3:0];
        r_hex1 <= r_bcd[7:4];
        r_hex2 <= r_bcd[11:8];
        r_hex3 <= r_bcd[15:12];
        r_hex5 <= 4'(r_vlat);
      end
    end
  end

  assign busy       = w_busy;
  assign curr_score = r_score;
  assign hex0_out   = r_hex0;
  assign hex1_out   = r_hex1;
  assign hex2_out   = r_hex2;
  assign hex3_out   = r_hex3;
  assign hex5_out   = r_hex5;

endmodule
